// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding and the default memory geometry.
package mips_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERROR
    } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader takes the slave side; the byte source / memory take master.
interface imem_loader_if
    import mips_pkg::*;
#(
    parameter int AW = AW_DEF
);

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts bytes big-endian into a 32-bit word.
// full pulses the cycle after the 4th byte, with the word held stable.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        last,
    output logic        full
);

    logic [1:0] cnt;

    assign last = shift && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            word <= 32'd0;
            cnt  <= 2'd0;
            full <= 1'b0;
        end else begin
            full <= last;
            if (clear) begin
                cnt <= 2'd0;
            end else if (shift) begin
                word <= {word[23:0], din};
                cnt  <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a counted, XOR-checksummed byte stream into instruction memory
// and releases the CPU from reset only after a clean load.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    localparam logic [7:0]  DEPTH8 = 8'(DEPTH);
    localparam logic [AW:0] ONE    = (AW + 1)'(1);

    ld_state_e   state, nstate;
    logic        take, cnt_ok;
    logic        pk_shift, pk_clear, pk_last, pk_full;
    logic [31:0] pk_word;
    logic [AW:0] nwords, word_idx;
    logic [7:0]  csum;

    assign take     = bus.in_valid && bus.in_ready;
    assign cnt_ok   = (bus.in_data != 8'd0) && (bus.in_data <= DEPTH8);
    assign pk_shift = (state == DATA) && take;
    assign pk_clear = (state == COUNT) && take && cnt_ok;

    byte_packer u_pack (
        .clk   (clk),
        .reset (reset),
        .clear (pk_clear),
        .shift (pk_shift),
        .din   (bus.in_data),
        .word  (pk_word),
        .last  (pk_last),
        .full  (pk_full)
    );

    // The write lands one cycle after word completion, so the index
    // is advanced on the strobe itself.
    assign bus.imem_we    = pk_full;
    assign bus.imem_addr  = word_idx[AW-1:0];
    assign bus.imem_wdata = pk_word;

    assign bus.in_ready = (state == COUNT) || (state == DATA) ||
                          (state == CHECK);
    assign done      = (state == DONE);
    assign error     = (state == ERROR);
    assign cpu_reset = (state != DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (start) nstate = COUNT;
            end
            COUNT: begin
                if (take) nstate = cnt_ok ? DATA : ERROR;
            end
            DATA: begin
                if (pk_last && ((word_idx + ONE) == nwords))
                    nstate = CHECK;
            end
            CHECK: begin
                if (take)
                    nstate = (bus.in_data == csum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start) nstate = COUNT;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nwords   <= '0;
            word_idx <= '0;
            csum     <= 8'd0;
        end else if (pk_clear) begin
            nwords   <= bus.in_data[AW:0];
            word_idx <= '0;
            csum     <= 8'd0;
        end else begin
            if (pk_full) word_idx <= word_idx + ONE;
            if (pk_shift) csum <= csum ^ bus.in_data;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a
// stream-level reference model (parse count, words, XOR checksum).
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset, done, error;

    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    wr_t got_q[$];
    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1)
            got_q.push_back({bus.imem_addr, bus.imem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input bq_t s, output bit e_done, output bit e_err);
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        n = int'(s[0]);
        e_done = 1'b0;
        e_err  = 1'b1;
        if (n == 0 || n > DEPTH) return;
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            w = {s[1+4*k], s[2+4*k], s[3+4*k], s[4+4*k]};
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            exp_q.push_back({AW'(k), w});
        end
        e_done = (s[1+4*n] == x);
        e_err  = !e_done;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random gaps
    task automatic send(input bq_t s, input int mode, input int poke);
        int  i = 0;
        int  cyc = 0;
        bit  poked = 1'b0;
        bit  v, acc;
        while (i < s.size() && cyc < 3000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            start = 1'b0;
            if (!poked && poke >= 0 && i == poke) begin
                poked = 1'b1;
                start = 1'b1;
                v = 1'b0;
            end
            bus.in_valid = v;
            bus.in_data  = v ? s[i] : 8'($urandom);
            acc = v && (bus.in_ready === 1'b1);
            @(posedge clk);
            if (acc) i++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        if (i < s.size()) chk("send_timeout", 32'(i), 32'(s.size()));
    endtask

    task automatic run(input bq_t s, input int mode, input int poke,
                       input string tag);
        bit ed, ee;
        got_q.delete();
        model(s, ed, ee);
        start_pulse();
        send(s, mode, poke);
        repeat (4) @(negedge clk);
        chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            chk({tag, "_addr"}, 32'(got_q[k].a), 32'(exp_q[k].a));
            chk({tag, "_data"}, got_q[k].d, exp_q[k].d);
        end
        chk({tag, "_done"}, 32'(done), 32'(ed));
        chk({tag, "_err"}, 32'(error), 32'(ee));
        chk({tag, "_cpurst"}, 32'(cpu_reset), 32'(!ed));
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    endtask

    bq_t s037, s038, s042, sbig, spart, sr;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        s037 = '{8'h02, 8'h01, 8'h0A, 8'h48, 8'h20,
                 8'h01, 8'h28, 8'h60, 8'h22, 8'h08};
        s038 = s037;
        s038[9] = 8'h09;
        s042 = '{8'h01, 8'h8D, 8'h0A, 8'h00, 8'h00, 8'h87};
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_cpurst", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);

        // bytes offered in IDLE must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("idle_rdy", 32'(bus.in_ready), 32'd0);
        chk("idle_nwr", 32'(got_q.size()), 32'd0);

        run(s037, 0, -1, "add_sub");
        run(s038, 0, -1, "badsum");
        run('{8'h00}, 0, -1, "cnt0");
        run('{8'h41}, 0, -1, "cnt65");
        run(s037, 1, -1, "toggle");

        // abort after the 5th data byte
        got_q.delete();
        spart = '{8'h02, 8'h01, 8'h0A, 8'h48, 8'h20, 8'h01};
        start_pulse();
        send(spart, 0, -1);
        repeat (2) @(negedge clk);
        chk("abort_nwr", 32'(got_q.size()), 32'd1);
        reset = 1'b1;
        got_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rst_nwr", 32'(got_q.size()), 32'd0);
        chk("abort_cpurst", 32'(cpu_reset), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr", 32'(bus.imem_addr), 32'd0);
        run(s037, 0, -1, "restart");

        run(s037, 0, 3, "poke");
        run(s042, 0, -1, "lw");

        // full-depth load touches every address
        sbig.delete();
        sbig.push_back(8'(DEPTH));
        begin
            logic [7:0] x = 8'd0;
            for (int k = 0; k < 4 * DEPTH; k++) begin
                logic [7:0] b = 8'($urandom);
                x ^= b;
                sbig.push_back(b);
            end
            sbig.push_back(x);
        end
        run(sbig, 2, -1, "full");

        for (int t = 0; t < 25; t++) begin
            int r = $urandom_range(0, 9);
            int n;
            logic [7:0] x = 8'd0;
            sr.delete();
            if (r == 0)      n = 0;
            else if (r == 1) n = $urandom_range(65, 255);
            else             n = $urandom_range(1, 6);
            sr.push_back(8'(n));
            if (n >= 1 && n <= DEPTH) begin
                for (int k = 0; k < 4 * n; k++) begin
                    logic [7:0] b = 8'($urandom);
                    x ^= b;
                    sr.push_back(b);
                end
                if ($urandom_range(0, 3) == 0)
                    x ^= 8'($urandom_range(1, 255));
                sr.push_back(x);
            end
            run(sr, $urandom_range(0, 2), -1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
